// File: rtl/arf_pkg.sv
// rtl/arf_pkg.sv - widths, default coefficients and multiply node for the ARF core (optional ARF_APPROX_EN)
package arf_pkg;

  localparam int IN_W     = 16;
  localparam int OUT_W    = 64;
  localparam int COEF_W   = 16;
  localparam int NUM_COEF = 16;
  localparam int NUM_IN   = 8;

  // C1 sits in the least significant slice; default Ck = k
  localparam logic [NUM_COEF*COEF_W-1:0] ARF_COEFS_DEF = {
    16'd16, 16'd15, 16'd14, 16'd13, 16'd12, 16'd11, 16'd10, 16'd9,
    16'd8,  16'd7,  16'd6,  16'd5,  16'd4,  16'd3,  16'd2,  16'd1
  };

  typedef logic [OUT_W-1:0] arf_word_t;

  // One multiply node of the graph; the approximate build drops the low nibble of every product
  function automatic arf_word_t mul_node(input arf_word_t a, input logic [COEF_W-1:0] c);
    arf_word_t p;
    p = a * arf_word_t'(c);
`ifdef ARF_APPROX_EN
    p[3:0] = 4'b0000;
`endif
    return p;
  endfunction

  // Coefficient Ck (1-based) out of the packed coefficient vector
  function automatic logic [COEF_W-1:0] coef_at(input logic [NUM_COEF*COEF_W-1:0] v, input int k);
    return v[(k-1)*COEF_W +: COEF_W];
  endfunction

endpackage

// File: rtl/arf_mac2.sv
// rtl/arf_mac2.sv - two-term multiply-accumulate (x*c_a)+(y*c_b) at 64 bits
module arf_mac2
  import arf_pkg::*;
(
  input  arf_word_t           x,
  input  arf_word_t           y,
  input  logic [COEF_W-1:0]   c_a,
  input  logic [COEF_W-1:0]   c_b,
  output arf_word_t           sum
);

  // Both products go through the shared multiply node so truncation applies uniformly
  assign sum = mul_node(x, c_a) + mul_node(y, c_b);

endmodule

// File: rtl/arf_filter_core.sv
// rtl/arf_filter_core.sv - pipelined fixed-coefficient ARF lattice datapath (ARF_APPROX_EN selects truncated multipliers)
module arf_filter_core
  import arf_pkg::*;
#(
  parameter logic [NUM_COEF*COEF_W-1:0] COEFS = ARF_COEFS_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [IN_W-1:0]   in_1,
  input  logic [IN_W-1:0]   in_2,
  input  logic [IN_W-1:0]   in_3,
  input  logic [IN_W-1:0]   in_4,
  input  logic [IN_W-1:0]   in_5,
  input  logic [IN_W-1:0]   in_6,
  input  logic [IN_W-1:0]   in_7,
  input  logic [IN_W-1:0]   in_8,
  output logic              out_valid,
  output logic [OUT_W-1:0]  out_27,
  output logic [OUT_W-1:0]  out_28
);

  localparam logic [COEF_W-1:0] C9  = coef_at(COEFS, 9);
  localparam logic [COEF_W-1:0] C10 = coef_at(COEFS, 10);
  localparam logic [COEF_W-1:0] C11 = coef_at(COEFS, 11);
  localparam logic [COEF_W-1:0] C12 = coef_at(COEFS, 12);
  localparam logic [COEF_W-1:0] C13 = coef_at(COEFS, 13);
  localparam logic [COEF_W-1:0] C14 = coef_at(COEFS, 14);
  localparam logic [COEF_W-1:0] C15 = coef_at(COEFS, 15);
  localparam logic [COEF_W-1:0] C16 = coef_at(COEFS, 16);

  logic [IN_W-1:0] in_vec [NUM_IN];
  logic [IN_W-1:0] smp_q  [NUM_IN];
  arf_word_t       m_q    [NUM_IN];
  logic            v0_q, v1_q, v2_q, v3_q;
  arf_word_t       a13_q, a14_q;
  arf_word_t       a19_q, a20_q, a13_d, a14_d;
  arf_word_t       a19_c, a20_c, a25_c, a26_c;

  assign in_vec[0] = in_1;
  assign in_vec[1] = in_2;
  assign in_vec[2] = in_3;
  assign in_vec[3] = in_4;
  assign in_vec[4] = in_5;
  assign in_vec[5] = in_6;
  assign in_vec[6] = in_7;
  assign in_vec[7] = in_8;

  // Input capture: samples are registered on the edge that sees in_valid, giving a four-edge result latency after that
  always_ff @(posedge clk) begin
    if (rst) begin
      v0_q <= 1'b0;
      for (int i = 0; i < NUM_IN; i++) smp_q[i] <= '0;
    end else begin
      v0_q <= in_valid;
      if (in_valid) begin
        for (int i = 0; i < NUM_IN; i++) smp_q[i] <= in_vec[i];
      end
    end
  end

  // S1: first-level products m1..m8
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q <= 1'b0;
      for (int i = 0; i < NUM_IN; i++) m_q[i] <= '0;
    end else begin
      v1_q <= v0_q;
      if (v0_q) begin
        for (int i = 0; i < NUM_IN; i++) begin
          m_q[i] <= mul_node(arf_word_t'(smp_q[i]), coef_at(COEFS, i + 1));
        end
      end
    end
  end

  // S2: adder tree a9..a12 folded into a13/a14
  always_ff @(posedge clk) begin
    if (rst) begin
      v2_q  <= 1'b0;
      a13_q <= '0;
      a14_q <= '0;
    end else begin
      v2_q <= v1_q;
      if (v1_q) begin
        a13_q <= (m_q[0] + m_q[1]) + (m_q[2] + m_q[3]);
        a14_q <= (m_q[4] + m_q[5]) + (m_q[6] + m_q[7]);
      end
    end
  end

  arf_mac2 u_mac_a19 (.x(a13_q), .y(a14_q), .c_a(C9),  .c_b(C11), .sum(a19_c));
  arf_mac2 u_mac_a20 (.x(a13_q), .y(a14_q), .c_a(C10), .c_b(C12), .sum(a20_c));

  // S3: lattice stage one, with a13/a14 delayed for the final feed-forward adds
  always_ff @(posedge clk) begin
    if (rst) begin
      v3_q  <= 1'b0;
      a19_q <= '0;
      a20_q <= '0;
      a13_d <= '0;
      a14_d <= '0;
    end else begin
      v3_q <= v2_q;
      if (v2_q) begin
        a19_q <= a19_c;
        a20_q <= a20_c;
        a13_d <= a13_q;
        a14_d <= a14_q;
      end
    end
  end

  arf_mac2 u_mac_a25 (.x(a19_q), .y(a20_q), .c_a(C13), .c_b(C15), .sum(a25_c));
  arf_mac2 u_mac_a26 (.x(a19_q), .y(a20_q), .c_a(C14), .c_b(C16), .sum(a26_c));

  // S4: lattice stage two plus feed-forward; results hold while no new set arrives
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_27    <= '0;
      out_28    <= '0;
    end else begin
      out_valid <= v3_q;
      if (v3_q) begin
        out_27 <= a25_c + a13_d;
        out_28 <= a26_c + a14_d;
      end
    end
  end

endmodule

// File: tb/tb_arf_filter_core.sv
// tb/tb_arf_filter_core.sv - scoreboard bench for arf_filter_core (honours ARF_APPROX_EN)
module tb_arf_filter_core;

  typedef struct {
    logic [63:0] e27;
    logic [63:0] e28;
    int          due;
  } exp_t;

  localparam logic [127:0] ALL1   = {8{16'd1}};
  localparam logic [127:0] P65535 = 128'h0000_0000_0000_0000_0000_0000_0000_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_1 = '0, in_2 = '0, in_3 = '0, in_4 = '0;
  logic [15:0] in_5 = '0, in_6 = '0, in_7 = '0, in_8 = '0;
  logic        out_valid;
  logic [63:0] out_27, out_28;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  exp_t        sb[$];
  logic [63:0] last_27 = '0, last_28 = '0;

  arf_filter_core dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .in_1(in_1), .in_2(in_2), .in_3(in_3), .in_4(in_4),
    .in_5(in_5), .in_6(in_6), .in_7(in_7), .in_8(in_8),
    .out_valid(out_valid), .out_27(out_27), .out_28(out_28)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [63:0] bmul(input logic [63:0] a, input int k);
    logic [63:0] p;
    p = a * 64'(k);
`ifdef ARF_APPROX_EN
    p[3:0] = 4'b0;
`endif
    return p;
  endfunction

  task automatic model(input logic [127:0] pk, output logic [63:0] o27, output logic [63:0] o28);
    logic [63:0] m [1:8];
    logic [63:0] a13, a14, a19, a20;
    for (int i = 1; i <= 8; i++) m[i] = bmul({48'd0, pk[16*(i-1) +: 16]}, i);
    a13 = m[1] + m[2] + m[3] + m[4];
    a14 = m[5] + m[6] + m[7] + m[8];
    a19 = bmul(a13, 9) + bmul(a14, 11);
    a20 = bmul(a13, 10) + bmul(a14, 12);
    o27 = bmul(a19, 13) + bmul(a20, 15) + a13;
    o28 = bmul(a19, 14) + bmul(a20, 16) + a14;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [127:0] pk, input logic v);
    in_valid = v;
    {in_8, in_7, in_6, in_5, in_4, in_3, in_2, in_1} = pk;
  endtask

  task automatic send_exp(input logic [127:0] pk, input logic [63:0] e27, input logic [63:0] e28);
    exp_t e;
    drive(pk, 1'b1);
    e.e27 = e27;
    e.e28 = e28;
    e.due = cyc + 5;
    sb.push_back(e);
    step();
  endtask

  task automatic send(input logic [127:0] pk);
    logic [63:0] o27, o28;
    model(pk, o27, o28);
    send_exp(pk, o27, o28);
  endtask

  task automatic send_dir(input int which);
`ifdef ARF_APPROX_EN
    if (which == 0) send_exp(ALL1, 64'd0, 64'd0);
    else send(P65535);
`else
    if (which == 0) send_exp(ALL1, 64'd11078, 64'd11882);
    else send_exp(P65535, 64'd17563380, 64'd18743010);
`endif
  endtask

  task automatic idle(input int n);
    drive('0, 1'b0);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    drive('0, 1'b0);
    while (sb.size() != 0 && budget < 20) begin
      step();
      budget++;
    end
    if (sb.size() != 0) check_val("drain_timeout", 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (out_valid) begin
      if (sb.size() == 0) begin
        check_val("unexpected_valid", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check_val("out_27", out_27, e.e27);
        check_val("out_28", out_28, e.e28);
        check_val("latency", 64'(cyc), 64'(e.due));
        last_27 = e.e27;
        last_28 = e.e28;
      end
    end
  end

  initial begin
    rst = 1'b1;
    step();
    step();
    check_val("rst_valid", {63'd0, out_valid}, 64'd0);
    check_val("rst_27", out_27, 64'd0);
    check_val("rst_28", out_28, 64'd0);
    rst = 1'b0;
    idle(1);

    send_dir(0);
    drain();
    send_dir(1);
    drain();

    send_dir(0);
    send_dir(1);
    drain();
    idle(3);
    check_val("hold_valid", {63'd0, out_valid}, 64'd0);
    check_val("hold_27", out_27, last_27);
    check_val("hold_28", out_28, last_28);

    for (int i = 0; i < 6; i++) send({$urandom, $urandom, $urandom, $urandom});
    send({8{16'hFFFF}});
    drain();

    send_dir(0);
    idle(1);
    rst = 1'b1;
    sb.delete();
    drive(ALL1, 1'b1);
    step();
    step();
    rst = 1'b0;
    idle(8);
    check_val("flush_valid", {63'd0, out_valid}, 64'd0);
    check_val("flush_27", out_27, 64'd0);
    check_val("flush_28", out_28, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
